nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
- Sequential wide adder that computes A+B+cin for a WIDTH-bit operand pair, one 4-bit slice per clock.
- Captures both operands on a start request and feeds the low nibble first into a single 4-bit ripple_carry_adder instance.
- Registers that adder's Sum into a result register and its Cout as the carry-in for the next slice.
- Sits directly upstream and downstream of the 4-bit adder. It lets the team build wide adders from one 4-bit slice, trading latency for area.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. NSLICE = WIDTH/4.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; sampled on rising edge
- a  input  WIDTH  operand A; sampled only when start is accepted
- b  input  WIDTH  operand B; sampled only when start is accepted
- cin  input  1  carry-in to slice 0; sampled only when start is accepted
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse: result outputs have just been updated
- sum  output  WIDTH  registered result of the last completed addition
- cout  output  1  carry out of the most significant slice
- overflow  output  1  two's-complement signed overflow of the last completed addition

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). rst has priority over every other input.
- Reset values:
  - state=IDLE, slice counter=0, carry register=0, operand and partial-result registers=0.
  - busy=0, done=0, sum=0, cout=0, overflow=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures a, b, cin into internal registers, clears the counter, and moves to RUN.
  - start=0 stays in IDLE.
- RUN:
  - In each cycle the adder sees operand nibble k, operand nibble k, and the carry register.
  - On the clock edge, Sum is written to partial-result nibble k and Cout to the carry register, then k increments.
  - After k=NSLICE-1 is written, the FSM moves to DONE.
  - Exactly NSLICE cycles are spent in RUN.
- DONE (one cycle):
  - sum, cout and overflow were loaded on the edge entering DONE. done=1 for this cycle only.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation) and moves to RUN. Otherwise the FSM moves to IDLE.
- Latency: start sampled at edge 0, busy high in cycles 1..NSLICE, done high in cycle NSLICE+1. For WIDTH=16, done rises 5 cycles after start.
- Throughput: one result every NSLICE+1 cycles.
- start while busy=1 is ignored. Operands are not re-sampled and the current operation is unaffected.
- sum, cout and overflow change only on entry to DONE or on reset. They hold their value otherwise, including during a subsequent RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Only the final carry is exposed; intermediate slice carries are internal.
- overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]), using the captured operands.
- Changes on a, b and cin after acceptance have no effect on the result.
- Reset mid-operation: returns to IDLE in the next cycle. No done pulse is produced. sum, cout and overflow are cleared to 0.
- Counter width is clog2(NSLICE), minimum 1 bit. For WIDTH=4 (NSLICE=1) the counter never increments and RUN lasts 1 cycle.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, start pulsed -> busy high for 4 cycles, done at cycle 5, sum=0x5555, cout=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all 4 slices: sum=0x0000, cout=1, overflow=0. Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, overflow=1.
- Start 0x0001+0x0001, then pulse start with a=0xAAAA in cycle 2 (busy) -> ignored: done at cycle 5 with sum=0x0002, and no second done.
- Hold start high through the DONE cycle with a=0x0F0F, b=0x00F1 -> first result is delivered; second done arrives 5 cycles later with sum=0x1000, cout=0.
- Start 0xFFFF+0xFFFF, assert rst in cycle 3 -> busy=0 and done=0 from the next cycle, sum=0, cout=0, overflow=0, no done pulse; a fresh start then completes normally.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses a single 4-bit ripple-carry slice, processing one nibble per clock.
// The low nibble is added first and the slice carry is registered between cycles.

module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  assign cout = carry[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] part;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] next_part;
  logic             last_slice;
  logic             ovf_next;

  // Select nibble k of both captured operands and splice the slice result into the partial sum.
  always_comb begin
    a_nib     = '0;
    b_nib     = '0;
    next_part = part;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CW'(i)) begin
        a_nib              = a_reg[4*i +: 4];
        b_nib              = b_reg[4*i +: 4];
        next_part[4*i +: 4] = slice_sum;
      end
    end
  end

  assign last_slice = (cnt == CW'(NSLICE - 1));
  assign ovf_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                      (next_part[WIDTH-1] != a_reg[WIDTH-1]);

  ripple_carry_adder u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // DONE accepts a new start exactly like IDLE so back-to-back operations lose no cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      part     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
            part  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          part  <= next_part;
          carry <= slice_cout;
          if (last_slice) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= next_part;
            cout     <= slice_cout;
            overflow <= ovf_next;
            state    <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
